// File: rtl/rr_distributor.sv
// rr_distributor
//   Round-robin distributor: one ready/valid input stream is spread across
//   four single-word output slots. Each slot is a full flag plus a data
//   register, and a new word goes to the first empty slot after the one
//   most recently loaded, wrapping around. With every consumer keeping up,
//   the words therefore go to slots 1, 2, 3, 0, ... in turn.
//
// Ports
//   clk                        clock, rising edge
//   reset                      synchronous, active-high; empties all slots
//   in_valid / in_ready        input handshake (in_ready = some slot empty)
//   in_bits   [WIDTH-1:0]      input payload
//   in_chosen [1:0]            slot the current input word would go to
//   out_K_valid / out_K_ready  per-slot output handshake, K = 0..3
//   out_K_bits [WIDTH-1:0]     per-slot payload, straight from the register
module rr_distributor #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic [1:0]       in_chosen,
  output logic             out_0_valid,
  input  logic             out_0_ready,
  output logic [WIDTH-1:0] out_0_bits,
  output logic             out_1_valid,
  input  logic             out_1_ready,
  output logic [WIDTH-1:0] out_1_bits,
  output logic             out_2_valid,
  input  logic             out_2_ready,
  output logic [WIDTH-1:0] out_2_bits,
  output logic             out_3_valid,
  input  logic             out_3_ready,
  output logic [WIDTH-1:0] out_3_bits
);

  logic [N-1:0]     full_p0;
  logic [WIDTH-1:0] data_p0 [N];
  logic [1:0]       last_p0;

  logic [N-1:0]     out_ready_w;
  logic [N-1:0]     load_mask;
  logic [1:0]       chosen;
  logic [1:0]       hi_idx;
  logic [1:0]       lo_idx;
  logic             hi_found;
  logic             lo_found;
  logic             in_fire;

  assign out_ready_w = {out_3_ready, out_2_ready, out_1_ready, out_0_ready};

  // in_ready depends only on the full flags, so a consumer's ready never
  // reaches the producer combinationally; a slot drained this cycle can be
  // reloaded next cycle at the earliest.
  assign in_ready  = ~&full_p0;
  assign in_fire   = in_valid & in_ready;
  assign in_chosen = chosen;

  // Scanning from the top down leaves the lowest matching index in each
  // candidate: hi_idx is the lowest empty slot above the last grant, and
  // lo_idx is the lowest empty slot overall, used when nothing above is free.
  always_comb begin
    hi_idx   = 2'd0;
    lo_idx   = 2'd0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    chosen   = 2'd3;
    for (int k = N - 1; k >= 0; k--) begin
      if (!full_p0[k]) begin
        lo_idx   = 2'(k);
        lo_found = 1'b1;
        if (2'(k) > last_p0) begin
          hi_idx   = 2'(k);
          hi_found = 1'b1;
        end
      end
    end
    if (hi_found) begin
      chosen = hi_idx;
    end else if (lo_found) begin
      chosen = lo_idx;
    end
  end

  assign load_mask = in_fire ? (N'(1) << chosen) : '0;

  // ---- stage p0: slot state registers ----
  // The input only ever loads an empty slot and the outputs only ever drain
  // full ones, so the clear and set masks never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_p0 <= '0;
      last_p0 <= 2'd0;
    end else begin
      full_p0 <= (full_p0 & ~out_ready_w) | load_mask;
      if (in_fire) begin
        last_p0 <= chosen;
      end
    end
  end

  // Payload registers are not reset; they load only into an empty slot,
  // so a word waiting to be taken is never overwritten.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      data_p0[chosen] <= in_bits;
    end
  end

  assign out_0_valid = full_p0[0];
  assign out_1_valid = full_p0[1];
  assign out_2_valid = full_p0[2];
  assign out_3_valid = full_p0[3];
  assign out_0_bits  = data_p0[0];
  assign out_1_bits  = data_p0[1];
  assign out_2_bits  = data_p0[2];
  assign out_3_bits  = data_p0[3];

endmodule

// File: tb/tb_rr_distributor.sv
// Testbench for rr_distributor: a round-robin reference model predicts
// in_ready / in_chosen / out_K_valid, and per-channel queues hold the
// payloads expected on each channel.
module tb_rr_distributor;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_bits;
  wire        in_ready;
  wire  [1:0] in_chosen;
  logic [3:0] out_ready;
  wire  [3:0] out_valid;
  wire  [7:0] out_bits [4];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] m_full = 4'b0;
  logic [1:0] m_last = 2'd0;
  logic [7:0] exp_q [4][$];

  // per-cycle predictions
  logic       exp_ready;
  logic [1:0] exp_chosen;
  logic [3:0] exp_valid;
  logic [3:0] out_fire;
  logic [3:0] pop_vld;
  logic [7:0] pop_val [4];
  logic       in_fire;

  always #5 clk = ~clk;

  rr_distributor #(.WIDTH(8), .N(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bits     (in_bits),
    .in_chosen   (in_chosen),
    .out_0_valid (out_valid[0]),
    .out_0_ready (out_ready[0]),
    .out_0_bits  (out_bits[0]),
    .out_1_valid (out_valid[1]),
    .out_1_ready (out_ready[1]),
    .out_1_bits  (out_bits[1]),
    .out_2_valid (out_valid[2]),
    .out_2_ready (out_ready[2]),
    .out_2_bits  (out_bits[2]),
    .out_3_valid (out_valid[3]),
    .out_3_ready (out_ready[3]),
    .out_3_bits  (out_bits[3])
  );

  // At the falling edge: predict this cycle's handshake from the model,
  // pop the words leaving and push the word entering.
  task automatic predict();
    logic [1:0] idx;
    logic       found;
    @(negedge clk);
    exp_valid  = m_full;
    exp_ready  = ~&m_full;
    exp_chosen = 2'd3;
    found      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = m_last + 2'(i) + 2'd1;
      if (!found && !m_full[idx]) begin
        exp_chosen = idx;
        found      = 1'b1;
      end
    end
    in_fire  = in_valid & exp_ready;
    out_fire = m_full & out_ready & {4{~reset}};
    for (int k = 0; k < 4; k++) begin
      pop_vld[k] = 1'b0;
      pop_val[k] = 8'h00;
      if (out_fire[k] && exp_q[k].size() > 0) begin
        pop_val[k] = exp_q[k].pop_front();
        pop_vld[k] = 1'b1;
      end
    end
    if (in_fire && !reset) exp_q[exp_chosen].push_back(in_bits);
  endtask

  // At the rising edge: move the model to its next state.
  task automatic advance();
    @(posedge clk);
    if (reset) begin
      m_full = 4'b0;
      m_last = 2'd0;
      for (int k = 0; k < 4; k++) exp_q[k].delete();
    end else begin
      m_full = m_full & ~out_fire;
      if (in_fire) begin
        m_full[exp_chosen] = 1'b1;
        m_last = exp_chosen;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_bits = 8'h00; out_ready = 4'b0;
    predict(); advance();
    predict(); advance();
    reset = 1'b0;
    predict();
    checks++;
    if (out_valid !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    checks++;
    if (in_chosen !== 2'd1) begin errors++; $display("FAIL reset_chosen: got %0d expected 1", in_chosen); end
    advance();
  endtask

  task automatic test_fill();
    logic [1:0] want [5];
    logic [7:0] dwant [4];
    want  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    dwant = '{8'hA4, 8'hA1, 8'hA2, 8'hA3};
    out_ready = 4'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_bits = 8'hA1 + 8'(i);
      predict();
      checks++;
      if (in_chosen !== want[i] || in_chosen !== exp_chosen) begin
        errors++; $display("FAIL fill_chosen[%0d]: got %0d expected %0d", i, in_chosen, want[i]);
      end
      checks++;
      if (in_ready !== (i < 4)) begin
        errors++; $display("FAIL fill_ready[%0d]: got %b expected %b", i, in_ready, (i < 4));
      end
      advance();
    end
    predict();
    checks++;
    if (out_valid !== 4'hF) begin errors++; $display("FAIL fill_valid: got %b expected 1111", out_valid); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_bits[k] !== dwant[k]) begin
        errors++; $display("FAIL fill_data[%0d]: got %h expected %h", k, out_bits[k], dwant[k]);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_held: got %b expected 0", in_ready); end
    advance();
  endtask

  task automatic test_drain_refill();
    in_valid  = 1'b1;
    in_bits   = 8'hA5;
    out_ready = 4'b0100;
    predict();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_cycle_ready: got %b expected 0", in_ready); end
    checks++;
    if (!pop_vld[2] || out_bits[2] !== pop_val[2] || out_valid[2] !== 1'b1) begin
      errors++; $display("FAIL drain_data2: got %h expected %h", out_bits[2], pop_val[2]);
    end
    advance();
    out_ready = 4'b0;
    predict();
    checks++;
    if (out_valid[2] !== 1'b0) begin errors++; $display("FAIL drain_valid2: got %b expected 0", out_valid[2]); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL refill_ready: got %b expected 1", in_ready); end
    checks++;
    if (in_chosen !== 2'd2) begin errors++; $display("FAIL refill_chosen: got %0d expected 2", in_chosen); end
    advance();
    in_valid = 1'b0;
    predict();
    checks++;
    if (out_valid !== 4'hF || out_bits[2] !== 8'hA5) begin
      errors++; $display("FAIL refill_data: got %b/%h expected 1111/a5", out_valid, out_bits[2]);
    end
    advance();
  endtask

  task automatic test_wrap();
    in_valid  = 1'b0;
    out_ready = 4'b1101;
    predict();
    for (int k = 0; k < 4; k++) if (pop_vld[k]) begin
      checks++;
      if (out_bits[k] !== pop_val[k]) begin
        errors++; $display("FAIL wrap_drain[%0d]: got %h expected %h", k, out_bits[k], pop_val[k]);
      end
    end
    advance();
    out_ready = 4'b0;
    in_valid  = 1'b1;
    in_bits   = 8'hB0;
    predict();
    checks++;
    if (in_chosen !== 2'd3) begin errors++; $display("FAIL wrap_pre_chosen: got %0d expected 3", in_chosen); end
    advance();
    in_bits = 8'hB1;
    predict();
    checks++;
    if (out_valid !== 4'b1010) begin errors++; $display("FAIL wrap_state: got %b expected 1010", out_valid); end
    checks++;
    if (in_chosen !== 2'd0) begin errors++; $display("FAIL wrap_chosen: got %0d expected 0", in_chosen); end
    advance();
    in_valid = 1'b0;
    predict();
    checks++;
    if (out_valid !== 4'b1011 || out_bits[0] !== 8'hB1) begin
      errors++; $display("FAIL wrap_load: got %b/%h expected 1011/b1", out_valid, out_bits[0]);
    end
    checks++;
    if (in_chosen !== exp_chosen) begin
      errors++; $display("FAIL wrap_next_chosen: got %0d expected %0d", in_chosen, exp_chosen);
    end
    advance();
    out_ready = 4'hF;
    predict();
    for (int k = 0; k < 4; k++) if (pop_vld[k]) begin
      checks++;
      if (out_bits[k] !== pop_val[k]) begin
        errors++; $display("FAIL wrap_flush[%0d]: got %h expected %h", k, out_bits[k], pop_val[k]);
      end
    end
    advance();
    out_ready = 4'b0;
  endtask

  task automatic test_simultaneous();
    reset = 1'b1; in_valid = 1'b0; out_ready = 4'b0;
    predict(); advance();
    reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_bits = 8'hC1 + 8'(i);
      predict(); advance();
    end
    in_valid  = 1'b0;
    out_ready = 4'b0010;
    predict(); advance();
    in_valid  = 1'b1;
    in_bits   = 8'hC5;
    out_ready = 4'b0001;
    predict();
    checks++;
    if (in_chosen !== 2'd1) begin errors++; $display("FAIL simul_chosen: got %0d expected 1", in_chosen); end
    checks++;
    if (!pop_vld[0] || out_bits[0] !== pop_val[0]) begin
      errors++; $display("FAIL simul_drain0: got %h expected %h", out_bits[0], pop_val[0]);
    end
    advance();
    in_valid  = 1'b0;
    out_ready = 4'b0;
    predict();
    checks++;
    if (out_valid !== 4'b1110) begin errors++; $display("FAIL simul_flags: got %b expected 1110", out_valid); end
    checks++;
    if (out_bits[0] !== 8'hC4 || out_bits[1] !== 8'hC5 || out_bits[2] !== 8'hC2 || out_bits[3] !== 8'hC3) begin
      errors++; $display("FAIL simul_data: got %h %h %h %h expected c4 c5 c2 c3",
                         out_bits[0], out_bits[1], out_bits[2], out_bits[3]);
    end
    advance();
    out_ready = 4'hF;
    predict();
    for (int k = 0; k < 4; k++) if (pop_vld[k]) begin
      checks++;
      if (out_bits[k] !== pop_val[k]) begin
        errors++; $display("FAIL simul_flush[%0d]: got %h expected %h", k, out_bits[k], pop_val[k]);
      end
    end
    advance();
    out_ready = 4'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] want [4];
    logic [3:0] vwant;
    want = '{2'd1, 2'd2, 2'd3, 2'd0};
    reset = 1'b1; in_valid = 1'b0; out_ready = 4'b0;
    predict(); advance();
    reset = 1'b0;
    out_ready = 4'hF;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_bits = 8'hD0 + 8'(i);
      predict();
      vwant = (i == 0) ? 4'b0 : (4'b1 << want[(i - 1) % 4]);
      checks++;
      if (in_chosen !== want[i % 4] || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_chosen[%0d]: got %0d/%b expected %0d/1", i, in_chosen, in_ready, want[i % 4]);
      end
      checks++;
      if (out_valid !== vwant || out_valid !== exp_valid) begin
        errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, out_valid, vwant);
      end
      for (int k = 0; k < 4; k++) if (pop_vld[k]) begin
        checks++;
        if (out_bits[k] !== pop_val[k]) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, out_bits[k], pop_val[k]);
        end
      end
      advance();
    end
    in_valid = 1'b0;
    predict();
    checks++;
    if (out_valid !== 4'b0001 || !pop_vld[0] || out_bits[0] !== pop_val[0]) begin
      errors++; $display("FAIL b2b_last: got %b/%h expected 0001/%h", out_valid, out_bits[0], pop_val[0]);
    end
    advance();
    predict();
    checks++;
    if (out_valid !== 4'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0000", out_valid); end
    advance();
    out_ready = 4'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_bits = 8'hE1 + 8'(i);
      predict(); advance();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    predict();
    checks++;
    if (out_valid !== 4'b1110) begin errors++; $display("FAIL rstmid_before: got %b expected 1110", out_valid); end
    advance();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_bits  = 8'hE4;
    predict();
    checks++;
    if (out_valid !== 4'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0000", out_valid); end
    checks++;
    if (in_chosen !== 2'd1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_chosen: got %0d/%b expected 1/1", in_chosen, in_ready);
    end
    advance();
    in_valid = 1'b0;
    predict();
    checks++;
    if (out_valid !== 4'b0010 || out_bits[1] !== 8'hE4) begin
      errors++; $display("FAIL rstmid_load: got %b/%h expected 0010/e4", out_valid, out_bits[1]);
    end
    advance();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bits = 8'h00; out_ready = 4'b0;
    test_reset();
    test_fill();
    test_drain_refill();
    test_wrap();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_distributor.md
RR_DISTRIBUTOR -- requirements
Module: rr_distributor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter N, fixed at 4: number of output channels; the index width is 2.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: producer offers a word.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts the word this cycle.
REQ-007 SHALL have port in_bits, input, WIDTH bits: offered payload.
REQ-008 SHALL have ports out_K_valid, output, 1 bit each (K = 0..3): slot K holds a word.
REQ-009 SHALL have ports out_K_ready, input, 1 bit each: consumer K takes the word.
REQ-010 SHALL have ports out_K_bits, output, WIDTH bits each: slot K payload.
REQ-011 SHALL have port in_chosen, output, 2 bits: slot index the current input word would be written to.

Function
REQ-012 SHALL hold, per slot K, a full flag F[K] and a data register D[K]; out_K_valid = F[K] and out_K_bits = D[K], both driven only from registers.
REQ-013 SHALL hold a last-grant pointer L (2 bits).
REQ-014 SHALL drive in_ready = OR over K of !F[K], with no combinational path from any out_K_ready.
REQ-015 SHALL set in_chosen to the lowest empty index strictly greater than L, if one exists.
REQ-016 SHALL otherwise set in_chosen to the lowest empty index overall (wrap-around).
REQ-017 SHALL drive in_chosen = 3 when all slots are full.
REQ-018 SHALL treat in_valid & in_ready as an input fire; on a fire, D[in_chosen] <= in_bits, F[in_chosen] <= 1 and L <= in_chosen at the next edge.
REQ-019 SHALL treat F[K] & out_K_ready as an output fire on slot K, clearing F[K] at the next edge; D[K] holds its value.
REQ-020 SHALL allow an input fire and any number of output fires in the same cycle; they target different slots by construction.
REQ-021 SHALL, when slot K drains in cycle c, accept a load into slot K no earlier than cycle c+1; F[K] is still 1 in cycle c.
REQ-022 SHALL keep L and all D unchanged when no input fire occurs, and SHALL never modify D[K] while F[K] = 1.
REQ-023 SHALL have a latency of exactly 1 cycle from input fire to out_K_valid.
REQ-024 SHALL sustain a throughput of one word per cycle while at least one slot is empty.
REQ-025 SHALL deliver words on each channel in their input order; ordering across channels is not guaranteed.

Reset
REQ-026 SHALL, while reset = 1, force F[0..3] = 0 and L = 0 at each edge; D is left undefined, and the block is then idle and empty.
REQ-027 SHALL, when reset is asserted mid-operation, discard all buffered words without any output fire; in_ready and in_chosen follow REQ-014/REQ-015/REQ-016/REQ-017 from current state regardless of reset.
REQ-028 SHALL, after reset, place the first accepted word in slot 1, because L = 0.

Verification
REQ-029 Bench SHALL cover: reset, all out_K_ready = 0, in_valid = 1 with bits 0xA1, 0xA2, 0xA3, 0xA4, 0xA5 on consecutive cycles -> in_chosen 1, 2, 3, 0; D1 = 0xA1, D2 = 0xA2, D3 = 0xA3, D0 = 0xA4; in_ready = 0 on the 5th cycle and 0xA5 held.
REQ-030 Bench SHALL cover: from that full state, out_2_ready = 1 for one cycle -> out_2_valid = 0 next cycle; in_ready = 1, in_chosen = 2; 0xA5 loads into slot 2 and L = 2.
REQ-031 Bench SHALL cover: L = 3, F = {0:empty, 1:full, 2:empty, 3:full}, in_valid = 1 -> in_chosen = 0 (wrap-around) and L <= 0.
REQ-032 Bench SHALL cover: slot 0 full with out_0_ready = 1 while the input loads slot 1 in the same cycle -> next cycle F0 = 0, F1 = 1, no data corruption.
REQ-033 Bench SHALL cover: all out_K_ready = 1, in_valid held for 8 cycles -> one fire per cycle, slot sequence 1, 2, 3, 0, 1, 2, 3, 0, each out_K_valid pulse exactly 1 cycle.
REQ-034 Bench SHALL cover: three slots full, reset pulsed for 1 cycle -> all out_K_valid = 0; the next word goes to slot 1.
